data_mem: RTL
=============

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-002 Parameter LATENCY, default 1, clock edges from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous to clk and active-high.
REQ-005 mem_ctrl  input  5  request control: [4] enable, [3] write, [2] unsigned, [1:0] size (00 byte, 01 half, 10 word, 11 illegal).
REQ-006 mem_addr  input  32  byte address.
REQ-007 mem_din  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 mem_dout  output  32  read data, right-aligned and extended.
REQ-009 mem_ready  output  1  one-cycle response strobe.
REQ-010 mem_err  output  1  response error flag, valid only while mem_ready=1.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-012 In IDLE, mem_ctrl[4]=1 at a rising edge SHALL accept the request: latch mem_ctrl, mem_addr, mem_din; go to WAIT if LATENCY>1, else RESP.
REQ-013 WAIT SHALL count LATENCY-1 edges (4-bit counter), then go to RESP.
REQ-014 mem_ready SHALL be 1 for exactly one cycle (RESP), beginning LATENCY edges after the acceptance edge.
REQ-015 From RESP the FSM SHALL return to IDLE; mem_ctrl[4]=1 in the following IDLE cycle is a new request (back-to-back allowed, one request per LATENCY+1 cycles).
REQ-016 Inputs SHALL be ignored outside IDLE; deasserting enable after acceptance SHALL NOT cancel the transaction.
REQ-017 Error SHALL be flagged when size=11, half access with addr[0]=1, word access with addr[1:0]!=0, or addr >= DEPTH_WORDS*4.
REQ-018 Errored transactions SHALL perform no write and drive mem_dout=0 with mem_err=1.
REQ-019 Writes SHALL update only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and +1; word: all), at the edge that raises mem_ready.
REQ-020 Reads SHALL return the selected lane(s) zero-extended if unsigned=1, else sign-extended; word reads return the full word.
REQ-021 Writes SHALL drive mem_dout=0 and mem_err=0 in the RESP cycle.
REQ-022 mem_dout and mem_err SHALL hold their RESP values until the next response or reset.
REQ-023 Word index SHALL be addr[31:2]; no wrap-around; out-of-range handled per REQ-017.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, counter 0, mem_ready=0, mem_err=0, mem_dout=0.
REQ-025 Reset mid-transaction SHALL drop the pending request: no write, no mem_ready pulse.
REQ-026 Storage contents SHALL NOT be cleared by reset.
REQ-027 A request present during the reset cycle SHALL NOT be accepted; acceptance begins at the first edge with rst=0.

Verification
REQ-028 LATENCY=1: word write addr 0x10 data 0xDEADBEEF, then word read 0x10 -> each mem_ready exactly 1 cycle after acceptance, read mem_dout=0xDEADBEEF, mem_err=0.
REQ-029 Byte write 0x80 to addr 0x13 over word 0x00000000, then signed byte read 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word read 0x10 -> 0x80000000.
REQ-030 Half read addr 0x11, word read 0x12, size=11, and addr 0x1000 (DEPTH_WORDS=1024) -> mem_err=1, mem_dout=0; a subsequent word read 0x10 shows prior contents unchanged.
REQ-031 LATENCY=4: read with enable held high 1 cycle only -> mem_ready pulses exactly 4 edges after acceptance; enable held high continuously -> next acceptance in the cycle after mem_ready.
REQ-032 LATENCY=3: word write 0x12345678 to 0x20, rst asserted 1 cycle in WAIT -> no mem_ready; word read 0x20 returns previous contents.

Source files
------------

// File: rtl/data_mem.sv
// Byte-addressable 32-bit data memory with a fixed, parameterised response latency.
// One request is taken in IDLE and answered by a one-cycle registered mem_ready strobe.
module data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_ctrl,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LAST  = 4'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [30:0] DEPTH_LIM = 31'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] dout_q, dout_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word, rd_ext, wr_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [3:0]       wr_be;
  logic             acc_err, do_write;

  assign mem_dout  = dout_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;

  // req_q holds {write, unsigned, size[1:0]} of the accepted request.
  always_comb begin
    word_idx = addr_q[IDX_W+1:2];
    rd_word  = mem[word_idx];
    acc_err  = ({1'b0, addr_q[31:2]} >= DEPTH_LIM);
    rd_ext   = rd_word;
    wr_word  = din_q;
    wr_be    = 4'b1111;
    case (addr_q[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_q[1:0])
      2'b00: begin
        rd_ext  = req_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        wr_word = {4{din_q[7:0]}};
        wr_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        rd_ext  = req_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
        wr_word = {2{din_q[15:0]}};
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        acc_err = acc_err | addr_q[0];
      end
      2'b10:   acc_err = acc_err | (addr_q[1:0] != 2'b00);
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ctrl[4]) begin
          req_d   = mem_ctrl[3:0];
          addr_d  = mem_addr;
          din_d   = mem_din;
          cnt_d   = 4'd0;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        err_d    = acc_err;
        do_write = req_q[3] && !acc_err;
        dout_d   = (req_q[3] || acc_err) ? 32'h0 : rd_ext;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= 4'd0;
      addr_q  <= 32'h0;
      din_q   <= 32'h0;
      dout_q  <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; a reset on the response edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule
